hav_seq_ctrl: RTL and testbench

Sequencer for the haversine "a" term of the distance datapath. It accepts one coordinate pair per job and walks a fixed 9-step microprogram over an internal adder and an external, shared 128×128 signed multiplier. Multiplier access uses a request/grant/valid handshake, so the multiplier can be arbitrated with other clients. The block sits between the coordinate front-end and the sqrt/atan back-end and produces `hav` with a one-cycle `done` pulse.

---
 rtl/hav_pkg.sv | 50 +++++
 rtl/hav_mul_port.sv | 78 +++++++
 rtl/hav_seq_ctrl.sv | 222 ++++++++++++++++++++++
 tb/tb_hav_seq_ctrl.sv | 384 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hav_pkg.sv
// hav_pkg: shared widths, constants, state encodings and helpers for the haversine sequencer.
package hav_pkg;

    localparam int unsigned W_COORD = 48;
    localparam int unsigned W_COS   = 64;
    localparam int unsigned W_OP    = 128;
    localparam int unsigned W_PROD  = 256;

    // Degrees to radians, Q0.32 value carried in the low bits of a Q16.32 word.
    localparam logic [31:0] RAD = 32'h0477_0000;

    // Product slice offsets: radian scaling keeps [128:1], squares and cos products keep [191:64].
    localparam int unsigned RAD_SLICE_LSB = 1;
    localparam int unsigned SQ_SLICE_LSB  = 64;

    typedef enum logic [3:0] {
        StIdle,
        StSubLon,
        StMulRlon,
        StSqLon,
        StMulCb,
        StMulCa,
        StSubLat,
        StMulRlat,
        StSqLat,
        StAdd,
        StDone
    } hav_state_e;

    typedef enum logic [1:0] {
        PortIdle,
        PortReq,
        PortWait
    } port_state_e;

    // Coordinates are sign-extended into the 128-bit datapath.
    function automatic logic [W_OP-1:0] sext_coord(input logic [W_COORD-1:0] c);
        return {{(W_OP - W_COORD){c[W_COORD-1]}}, c};
    endfunction

    function automatic logic [W_OP-1:0] zext_cos(input logic [W_COS-1:0] c);
        return {{(W_OP - W_COS){1'b0}}, c};
    endfunction

    function automatic logic [W_OP-1:0] prod_slice(input logic [W_PROD-1:0] p,
                                                   input int unsigned lsb);
        return W_OP'(p >> lsb);
    endfunction

endpackage

// File: rtl/hav_mul_port.sv
// hav_mul_port: request/grant/valid handshake towards the shared multiplier.
// A launch loads operands and raises the request; the grant cycle moves to waiting,
// and the first valid product while waiting produces a one-cycle capture strobe.
module hav_mul_port
    import hav_pkg::*;
(
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic            launch_i,
    input  logic [W_OP-1:0] op_a_i,
    input  logic [W_OP-1:0] op_b_i,
    input  logic            mul_gnt_i,
    input  logic            mul_vld_i,
    output logic            mul_req_o,
    output logic [W_OP-1:0] mul_a_o,
    output logic [W_OP-1:0] mul_b_o,
    output logic            cap_o
);

    port_state_e     st_q;
    logic            req_q;
    logic [W_OP-1:0] a_q;
    logic [W_OP-1:0] b_q;

    // Handshake FSM with registered request and operands held stable until the grant.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            st_q  <= PortIdle;
            req_q <= 1'b0;
            a_q   <= '0;
            b_q   <= '0;
        end else begin
            unique case (st_q)
                PortIdle: begin
                    if (launch_i) begin
                        st_q  <= PortReq;
                        req_q <= 1'b1;
                        a_q   <= op_a_i;
                        b_q   <= op_b_i;
                    end
                end
                PortReq: begin
                    if (mul_gnt_i) begin
                        st_q  <= PortWait;
                        req_q <= 1'b0;
                    end
                end
                PortWait: begin
                    // A capture may immediately chain into the next multiply.
                    if (mul_vld_i) begin
                        if (launch_i) begin
                            st_q  <= PortReq;
                            req_q <= 1'b1;
                            a_q   <= op_a_i;
                            b_q   <= op_b_i;
                        end else begin
                            st_q <= PortIdle;
                        end
                    end
                end
                default: begin
                    st_q  <= PortIdle;
                    req_q <= 1'b0;
                end
            endcase
        end
    end

    // Valid is only meaningful after our own grant; anything else is ignored.
    always_comb begin
        cap_o = (st_q == PortWait) && mul_vld_i;
    end

    assign mul_req_o = req_q;
    assign mul_a_o   = a_q;
    assign mul_b_o   = b_q;

endmodule

// File: rtl/hav_seq_ctrl.sv
// hav_seq_ctrl: walks the fixed haversine "a" microprogram over an adder and a shared multiplier.
// t accumulates the longitude term, u the latitude term; hav = t + u.
module hav_seq_ctrl
    import hav_pkg::*;
#(
    parameter logic [31:0] Rad = RAD
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               start_i,
    input  logic [W_COORD-1:0] lon_a_i,
    input  logic [W_COORD-1:0] lon_b_i,
    input  logic [W_COORD-1:0] lat_a_i,
    input  logic [W_COORD-1:0] lat_b_i,
    input  logic [W_COS-1:0]   cos_a_i,
    input  logic [W_COS-1:0]   cos_b_i,
    output logic               busy_o,
    output logic               done_o,
    output logic [W_OP-1:0]    hav_o,
    output logic               mul_req_o,
    output logic [W_OP-1:0]    mul_a_o,
    output logic [W_OP-1:0]    mul_b_o,
    input  logic               mul_gnt_i,
    input  logic               mul_vld_i,
    input  logic [W_PROD-1:0]  mul_p_i
);

    hav_state_e         state_q;
    logic [W_COORD-1:0] lon_a_q;
    logic [W_COORD-1:0] lon_b_q;
    logic [W_COORD-1:0] lat_a_q;
    logic [W_COORD-1:0] lat_b_q;
    logic [W_COS-1:0]   cos_a_q;
    logic [W_COS-1:0]   cos_b_q;
    logic [W_OP-1:0]    t_q;
    logic [W_OP-1:0]    u_q;
    logic [W_OP-1:0]    hav_q;
    logic               busy_q;
    logic               done_q;

    logic [W_OP-1:0]    rad_ext;
    logic [W_OP-1:0]    lon_diff;
    logic [W_OP-1:0]    lat_diff;
    logic [W_OP-1:0]    slice_rad;
    logic [W_OP-1:0]    slice_sq;
    logic [W_OP-1:0]    step_d;
    logic               launch_d;
    logic [W_OP-1:0]    op_a_d;
    logic [W_OP-1:0]    op_b_d;
    logic               cap;

    assign rad_ext   = {{(W_OP - 32){1'b0}}, Rad};
    assign lon_diff  = sext_coord(lon_a_q) - sext_coord(lon_b_q);
    assign lat_diff  = sext_coord(lat_a_q) - sext_coord(lat_b_q);
    assign slice_rad = prod_slice(mul_p_i, RAD_SLICE_LSB);
    assign slice_sq  = prod_slice(mul_p_i, SQ_SLICE_LSB);

    // Per-state step result and the operands of the following multiply, launched on the
    // same edge the step result is stored so the request is up in the first MUL cycle.
    always_comb begin
        step_d   = '0;
        launch_d = 1'b0;
        op_a_d   = '0;
        op_b_d   = '0;
        unique case (state_q)
            StSubLon: begin
                step_d   = lon_diff;
                launch_d = 1'b1;
                op_a_d   = lon_diff;
                op_b_d   = rad_ext;
            end
            StMulRlon: begin
                step_d   = slice_rad;
                launch_d = cap;
                op_a_d   = slice_rad;
                op_b_d   = slice_rad;
            end
            StSqLon: begin
                step_d   = slice_sq;
                launch_d = cap;
                op_a_d   = slice_sq;
                op_b_d   = zext_cos(cos_b_q);
            end
            StMulCb: begin
                step_d   = slice_sq;
                launch_d = cap;
                op_a_d   = slice_sq;
                op_b_d   = zext_cos(cos_a_q);
            end
            StMulCa: begin
                step_d = slice_sq;
            end
            StSubLat: begin
                step_d   = lat_diff;
                launch_d = 1'b1;
                op_a_d   = lat_diff;
                op_b_d   = rad_ext;
            end
            StMulRlat: begin
                step_d   = slice_rad;
                launch_d = cap;
                op_a_d   = slice_rad;
                op_b_d   = slice_rad;
            end
            StSqLat: begin
                step_d = slice_sq;
            end
            default: begin
            end
        endcase
    end

    // Main sequencer: state, captured job inputs, intermediates and registered outputs.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= StIdle;
            lon_a_q <= '0;
            lon_b_q <= '0;
            lat_a_q <= '0;
            lat_b_q <= '0;
            cos_a_q <= '0;
            cos_b_q <= '0;
            t_q     <= '0;
            u_q     <= '0;
            hav_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start_i) begin
                        lon_a_q <= lon_a_i;
                        lon_b_q <= lon_b_i;
                        lat_a_q <= lat_a_i;
                        lat_b_q <= lat_b_i;
                        cos_a_q <= cos_a_i;
                        cos_b_q <= cos_b_i;
                        busy_q  <= 1'b1;
                        state_q <= StSubLon;
                    end
                end
                StSubLon: begin
                    t_q     <= step_d;
                    state_q <= StMulRlon;
                end
                StMulRlon: begin
                    if (cap) begin
                        t_q     <= step_d;
                        state_q <= StSqLon;
                    end
                end
                StSqLon: begin
                    if (cap) begin
                        t_q     <= step_d;
                        state_q <= StMulCb;
                    end
                end
                StMulCb: begin
                    if (cap) begin
                        t_q     <= step_d;
                        state_q <= StMulCa;
                    end
                end
                StMulCa: begin
                    if (cap) begin
                        t_q     <= step_d;
                        state_q <= StSubLat;
                    end
                end
                StSubLat: begin
                    u_q     <= step_d;
                    state_q <= StMulRlat;
                end
                StMulRlat: begin
                    if (cap) begin
                        u_q     <= step_d;
                        state_q <= StSqLat;
                    end
                end
                StSqLat: begin
                    if (cap) begin
                        u_q     <= step_d;
                        state_q <= StAdd;
                    end
                end
                StAdd: begin
                    hav_q   <= t_q + u_q;
                    done_q  <= 1'b1;
                    state_q <= StDone;
                end
                StDone: begin
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    hav_mul_port u_mul_port (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .launch_i  (launch_d),
        .op_a_i    (op_a_d),
        .op_b_i    (op_b_d),
        .mul_gnt_i (mul_gnt_i),
        .mul_vld_i (mul_vld_i),
        .mul_req_o (mul_req_o),
        .mul_a_o   (mul_a_o),
        .mul_b_o   (mul_b_o),
        .cap_o     (cap)
    );

    assign busy_o = busy_q;
    assign done_o = done_q;
    assign hav_o  = hav_q;

endmodule

// File: tb/tb_hav_seq_ctrl.sv
// tb_hav_seq_ctrl: randomized self-checking bench with a multiplier responder and a
// reference model that evaluates the haversine term with plain wide arithmetic.
module tb_hav_seq_ctrl;

    logic         clk_i = 1'b0;
    logic         reset_i;
    logic         start_i;
    logic [47:0]  lon_a_i, lon_b_i, lat_a_i, lat_b_i;
    logic [63:0]  cos_a_i, cos_b_i;
    logic         busy_o, done_o;
    logic [127:0] hav_o;
    logic         mul_req_o;
    logic [127:0] mul_a_o, mul_b_o;
    logic         mul_gnt_i, mul_vld_i;
    logic [255:0] mul_p_i;

    int total = 0;
    int bad   = 0;

    // Multiplier responder configuration and bookkeeping.
    int           lat        = 1;
    int           stall_idx  = -1;
    int           stall_left = 0;
    bit           spurious   = 1'b0;
    int           hs_count   = 0;
    bit           stall_seen = 1'b0;
    bit           stall_unstable = 1'b0;
    logic [127:0] stall_a, stall_b;
    bit           pend = 1'b0;
    int           pend_cnt = 0;
    logic [255:0] pend_p;

    localparam logic [127:0] ONE_DEG_HAV = 128'h4F_BD44_0000_000;

    hav_seq_ctrl dut (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .start_i   (start_i),
        .lon_a_i   (lon_a_i),
        .lon_b_i   (lon_b_i),
        .lat_a_i   (lat_a_i),
        .lat_b_i   (lat_b_i),
        .cos_a_i   (cos_a_i),
        .cos_b_i   (cos_b_i),
        .busy_o    (busy_o),
        .done_o    (done_o),
        .hav_o     (hav_o),
        .mul_req_o (mul_req_o),
        .mul_a_o   (mul_a_o),
        .mul_b_o   (mul_b_o),
        .mul_gnt_i (mul_gnt_i),
        .mul_vld_i (mul_vld_i),
        .mul_p_i   (mul_p_i)
    );

    initial forever #5 clk_i = ~clk_i;

    function automatic logic [47:0] rnd48();
        logic [63:0] w;
        w = {$urandom, $urandom};
        return w[47:0];
    endfunction

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    function automatic logic [255:0] smul(input logic [127:0] a, input logic [127:0] b);
        logic signed [255:0] ea, eb;
        ea = {{128{a[127]}}, a};
        eb = {{128{b[127]}}, b};
        return ea * eb;
    endfunction

    function automatic logic [127:0] sx48(input logic [47:0] v);
        return {{80{v[47]}}, v};
    endfunction

    // Reference: sin(x) ~ x, hav = (dlon*rad)^2*cos_b*cos_a + (dlat*rad)^2 with fixed slices.
    function automatic logic [127:0] model_hav(input logic [47:0] la, input logic [47:0] lb,
                                               input logic [47:0] ta, input logic [47:0] tb,
                                               input logic [63:0] ca, input logic [63:0] cb);
        logic [255:0] p;
        logic [127:0] t, u, rad;
        rad = 128'h0477_0000;
        t = sx48(la) - sx48(lb);
        p = smul(t, rad);          t = p[128:1];
        p = smul(t, t);            t = p[191:64];
        p = smul(t, {64'd0, cb});  t = p[191:64];
        p = smul(t, {64'd0, ca});  t = p[191:64];
        u = sx48(ta) - sx48(tb);
        p = smul(u, rad);          u = p[128:1];
        p = smul(u, u);            u = p[191:64];
        return t + u;
    endfunction

    // Shared multiplier model, driven on the falling edge.
    initial begin
        mul_gnt_i = 1'b0;
        mul_vld_i = 1'b0;
        mul_p_i   = '0;
        forever begin
            @(negedge clk_i);
            mul_gnt_i = 1'b0;
            mul_vld_i = 1'b0;
            if (pend) begin
                pend_cnt--;
                if (pend_cnt == 0) begin
                    mul_vld_i = 1'b1;
                    mul_p_i   = pend_p;
                    pend      = 1'b0;
                end
            end
            if (stall_seen && stall_left > 0 && !mul_req_o) stall_unstable = 1'b1;
            if (mul_req_o) begin
                if (stall_seen && (mul_a_o !== stall_a || mul_b_o !== stall_b))
                    stall_unstable = 1'b1;
                if (hs_count == stall_idx && stall_left > 0) begin
                    stall_left--;
                    if (!stall_seen) begin
                        stall_seen = 1'b1;
                        stall_a    = mul_a_o;
                        stall_b    = mul_b_o;
                    end
                    if (spurious) begin
                        mul_vld_i = 1'b1;
                        mul_p_i   = {rnd64(), rnd64(), rnd64(), rnd64()};
                    end
                end else begin
                    mul_gnt_i = 1'b1;
                    hs_count++;
                    pend     = 1'b1;
                    pend_cnt = lat;
                    pend_p   = smul(mul_a_o, mul_b_o);
                    stall_seen = 1'b0;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic cfg(input int l, input int sidx, input int slen, input bit spur);
        lat            = l;
        stall_idx      = sidx;
        stall_left     = slen;
        spurious       = spur;
        hs_count       = 0;
        stall_seen     = 1'b0;
        stall_unstable = 1'b0;
    endtask

    // Runs one job; edge 0 is the edge sampling start, k counts edges after it.
    task automatic run_job(input logic [47:0] la, input logic [47:0] lb,
                           input logic [47:0] ta, input logic [47:0] tb,
                           input logic [63:0] ca, input logic [63:0] cb,
                           input int extra_at, input int tail,
                           output int done_at, output int n_done,
                           output logic [127:0] h, output bit busy_bad);
        done_at  = -1;
        n_done   = 0;
        h        = '0;
        busy_bad = 1'b0;
        @(negedge clk_i);
        lon_a_i = la; lon_b_i = lb; lat_a_i = ta; lat_b_i = tb;
        cos_a_i = ca; cos_b_i = cb;
        start_i = 1'b1;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        lon_a_i = rnd48(); lon_b_i = rnd48(); lat_a_i = rnd48(); lat_b_i = rnd48();
        cos_a_i = rnd64(); cos_b_i = rnd64();
        for (int k = 0; k < 400; k++) begin
            if (k > 0) begin
                @(posedge clk_i); #1;
                start_i = 1'b0;
            end
            if (done_o === 1'b1) begin
                n_done++;
                if (done_at < 0) begin
                    done_at = k;
                    h       = hav_o;
                end
            end
            if (busy_o !== ((done_at < 0) || (k == done_at))) busy_bad = 1'b1;
            if (done_at >= 0 && k >= done_at + tail) break;
            if (k == extra_at) start_i = 1'b1;
        end
    endtask

    task automatic test_reset;
        reset_i = 1'b1;
        start_i = 1'b0;
        lon_a_i = '0; lon_b_i = '0; lat_a_i = '0; lat_b_i = '0; cos_a_i = '0; cos_b_i = '0;
        repeat (2) @(posedge clk_i);
        #1;
        total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy_o); end
        total++; if (done_o !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", done_o); end
        total++; if (hav_o !== '0) begin bad++; $display("FAIL reset_hav: got %h want 0", hav_o); end
        total++; if (mul_req_o !== 1'b0) begin bad++; $display("FAIL reset_req: got %b want 0", mul_req_o); end
        total++; if (mul_a_o !== '0) begin bad++; $display("FAIL reset_mul_a: got %h want 0", mul_a_o); end
        total++; if (mul_b_o !== '0) begin bad++; $display("FAIL reset_mul_b: got %h want 0", mul_b_o); end
        reset_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL idle_busy: got %b want 0", busy_o); end
    endtask

    task automatic test_equal;
        logic [47:0]  lo, la;
        int           d, n;
        logic [127:0] h;
        bit           bb;
        lo = rnd48(); la = rnd48();
        cfg(1, -1, 0, 1'b0);
        run_job(lo, lo, la, la, rnd64(), rnd64(), -1, 35, d, n, h, bb);
        total++; if (h !== '0) begin bad++; $display("FAIL equal_hav: got %h want 0", h); end
        total++; if (d != 15) begin bad++; $display("FAIL equal_done_cycle: got %0d want 15", d); end
        total++; if (n != 1) begin bad++; $display("FAIL equal_done_count: got %0d want 1", n); end
        total++; if (bb) begin bad++; $display("FAIL equal_busy: got mismatch want high through done only"); end
    endtask

    task automatic test_one_degree;
        logic [47:0]  lo;
        int           d, n;
        logic [127:0] h;
        bit           bb;
        lo = rnd48();
        cfg(1, -1, 0, 1'b0);
        run_job(lo, lo, 48'h0001_0000_0000, 48'h0, '1, '1, -1, 3, d, n, h, bb);
        total++; if (h !== ONE_DEG_HAV) begin bad++; $display("FAIL one_deg_hav: got %h want %h", h, ONE_DEG_HAV); end
        total++; if (d != 15) begin bad++; $display("FAIL one_deg_done: got %0d want 15", d); end
        cfg(1, -1, 0, 1'b0);
        run_job(lo, lo, 48'h0, 48'h0001_0000_0000, '1, '1, -1, 3, d, n, h, bb);
        total++; if (h !== ONE_DEG_HAV) begin bad++; $display("FAIL one_deg_neg_hav: got %h want %h", h, ONE_DEG_HAV); end
        total++; if (n != 1) begin bad++; $display("FAIL one_deg_neg_count: got %0d want 1", n); end
    endtask

    task automatic test_random;
        logic [47:0]  la, lb, ta, tb;
        logic [63:0]  ca, cb;
        logic [127:0] h, exp_h;
        int           d, n, l;
        bit           bb;
        for (int i = 0; i < 10; i++) begin
            la = rnd48(); lb = rnd48(); ta = rnd48(); tb = rnd48();
            ca = rnd64(); cb = rnd64();
            l  = int'($urandom_range(1, 3));
            exp_h = model_hav(la, lb, ta, tb, ca, cb);
            cfg(l, -1, 0, 1'b0);
            run_job(la, lb, ta, tb, ca, cb, -1, 2, d, n, h, bb);
            total++; if (h !== exp_h) begin bad++; $display("FAIL rand_hav[%0d]: got %h want %h", i, h, exp_h); end
            total++; if (d != 3 + 6 * (1 + l)) begin bad++; $display("FAIL rand_done[%0d]: got %0d want %0d", i, d, 3 + 6 * (1 + l)); end
            total++; if (bb) begin bad++; $display("FAIL rand_busy[%0d]: got mismatch want high through done only", i); end
        end
    endtask

    task automatic test_stall;
        logic [47:0]  la, lb, ta, tb;
        logic [63:0]  ca, cb;
        logic [127:0] h, exp_h;
        int           d, n;
        bit           bb;
        la = rnd48(); lb = rnd48(); ta = rnd48(); tb = rnd48(); ca = rnd64(); cb = rnd64();
        exp_h = model_hav(la, lb, ta, tb, ca, cb);
        // Third multiply of the job is MUL_CB.
        cfg(1, 2, 5, 1'b1);
        run_job(la, lb, ta, tb, ca, cb, -1, 35, d, n, h, bb);
        total++; if (d != 20) begin bad++; $display("FAIL stall_done: got %0d want 20", d); end
        total++; if (stall_unstable) begin bad++; $display("FAIL stall_stable: got changing req/operands want stable"); end
        total++; if (stall_left != 0) begin bad++; $display("FAIL stall_len: got %0d left want 0", stall_left); end
        total++; if (h !== exp_h) begin bad++; $display("FAIL stall_hav: got %h want %h", h, exp_h); end
        total++; if (n != 1) begin bad++; $display("FAIL stall_count: got %0d want 1", n); end
    endtask

    task automatic test_busy_start;
        logic [47:0]  la, lb, ta, tb;
        logic [63:0]  ca, cb;
        logic [127:0] h, exp_h;
        int           d, n;
        bit           bb;
        la = rnd48(); lb = rnd48(); ta = rnd48(); tb = rnd48(); ca = rnd64(); cb = rnd64();
        exp_h = model_hav(la, lb, ta, tb, ca, cb);
        cfg(3, -1, 0, 1'b0);
        run_job(la, lb, ta, tb, ca, cb, 5, 35, d, n, h, bb);
        total++; if (d != 27) begin bad++; $display("FAIL busy_start_done: got %0d want 27", d); end
        total++; if (n != 1) begin bad++; $display("FAIL busy_start_count: got %0d want 1", n); end
        total++; if (bb) begin bad++; $display("FAIL busy_start_busy: got mismatch want high through done only"); end
        total++; if (h !== exp_h) begin bad++; $display("FAIL busy_start_hav: got %h want %h", h, exp_h); end
    endtask

    task automatic test_back_to_back;
        logic [47:0]  la, lb, ta, tb;
        logic [63:0]  ca, cb;
        logic [127:0] h, exp_h;
        int           d, n;
        bit           bb;
        for (int j = 0; j < 2; j++) begin
            la = rnd48(); lb = rnd48(); ta = rnd48(); tb = rnd48(); ca = rnd64(); cb = rnd64();
            exp_h = model_hav(la, lb, ta, tb, ca, cb);
            cfg(1, -1, 0, 1'b0);
            run_job(la, lb, ta, tb, ca, cb, -1, 1, d, n, h, bb);
            total++; if (h !== exp_h) begin bad++; $display("FAIL b2b_hav[%0d]: got %h want %h", j, h, exp_h); end
            total++; if (d != 15) begin bad++; $display("FAIL b2b_done[%0d]: got %0d want 15", j, d); end
        end
    endtask

    task automatic launch_only(input logic [47:0] la, input logic [47:0] lb,
                               input logic [47:0] ta, input logic [47:0] tb);
        @(negedge clk_i);
        lon_a_i = la; lon_b_i = lb; lat_a_i = ta; lat_b_i = tb;
        cos_a_i = rnd64(); cos_b_i = rnd64();
        start_i = 1'b1;
        @(posedge clk_i); #1;
        start_i = 1'b0;
    endtask

    task automatic test_reset_mid;
        logic [47:0]  la, lb, ta, tb;
        logic [63:0]  ca, cb;
        logic [127:0] h, exp_h;
        int           d, n, w;
        bit           bb;
        // Reset while a request is stalled: the request must drop without a clock edge.
        cfg(2, 2, 50, 1'b0);
        launch_only(rnd48(), rnd48(), rnd48(), rnd48());
        w = 0;
        while (!(mul_req_o === 1'b1 && hs_count == 2) && w < 100) begin
            @(posedge clk_i); #1;
            w++;
        end
        total++; if (w >= 100) begin bad++; $display("FAIL mid_req_wait: got timeout want MUL_CB request"); end
        #2 reset_i = 1'b1;
        #1;
        total++; if (mul_req_o !== 1'b0) begin bad++; $display("FAIL mid_req_async: got %b want 0", mul_req_o); end
        @(posedge clk_i); #1;
        reset_i = 1'b0;
        // Reset during SQ_LAT wait, with its product still to arrive afterwards.
        cfg(3, -1, 0, 1'b0);
        launch_only(rnd48(), rnd48(), rnd48(), rnd48());
        w = 0;
        while (hs_count < 6 && w < 200) begin
            @(posedge clk_i); #1;
            w++;
        end
        total++; if (w >= 200) begin bad++; $display("FAIL mid_sqlat_wait: got timeout want SQ_LAT grant"); end
        reset_i = 1'b1;
        @(posedge clk_i); #1;
        reset_i = 1'b0;
        for (int c = 0; c < 8; c++) begin
            total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL mid_busy[%0d]: got %b want 0", c, busy_o); end
            total++; if (done_o !== 1'b0) begin bad++; $display("FAIL mid_done[%0d]: got %b want 0", c, done_o); end
            total++; if (hav_o !== '0) begin bad++; $display("FAIL mid_hav[%0d]: got %h want 0", c, hav_o); end
            total++; if (mul_req_o !== 1'b0 || mul_a_o !== '0 || mul_b_o !== '0) begin
                bad++;
                $display("FAIL mid_mul[%0d]: got req=%b a=%h b=%h want all 0", c, mul_req_o, mul_a_o, mul_b_o);
            end
            @(posedge clk_i); #1;
        end
        la = rnd48(); lb = rnd48(); ta = rnd48(); tb = rnd48(); ca = rnd64(); cb = rnd64();
        exp_h = model_hav(la, lb, ta, tb, ca, cb);
        cfg(1, -1, 0, 1'b0);
        run_job(la, lb, ta, tb, ca, cb, -1, 2, d, n, h, bb);
        total++; if (h !== exp_h) begin bad++; $display("FAIL post_reset_hav: got %h want %h", h, exp_h); end
        total++; if (d != 15) begin bad++; $display("FAIL post_reset_done: got %0d want 15", d); end
    endtask

    initial begin
        test_reset();
        test_equal();
        test_one_degree();
        test_random();
        test_stall();
        test_busy_start();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
